// File: rtl/fir_ctrl_if.sv
// Bundle of the fir_ctrl bus-side signals: upstream samples, result strobe,
// host coefficient access and the FIR core port.
//   slave  : fir_ctrl side (drives s_ready, m_*, cfg_ack/rdata/err, fir_* controls, sample_cnt)
//   master : environment side (upstream source, host, FIR core)
interface fir_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 16;

  // upstream sample stream
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  // result strobe
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  // host coefficient access
  logic                  cfg_req;
  logic                  cfg_we;
  logic [ADDR_W-1:0]     cfg_addr;
  logic [DATA_WIDTH-1:0] cfg_wdata;
  logic                  cfg_ack;
  logic [DATA_WIDTH-1:0] cfg_rdata;
  logic                  cfg_err;
  // FIR core port
  logic                  fir_valid;
  logic [DATA_WIDTH-1:0] fir_sample;
  logic [DATA_WIDTH-1:0] fir_result;
  logic                  fir_we;
  logic [ADDR_W-1:0]     fir_addr;
  logic [DATA_WIDTH-1:0] fir_wdata;
  logic [DATA_WIDTH-1:0] fir_rdata;
  // results emitted
  logic [CNT_W-1:0]      sample_cnt;

  modport slave (
    input  s_valid, s_data, cfg_req, cfg_we, cfg_addr, cfg_wdata, fir_result, fir_rdata,
    output s_ready, m_valid, m_data, cfg_ack, cfg_rdata, cfg_err,
           fir_valid, fir_sample, fir_we, fir_addr, fir_wdata, sample_cnt
  );

  modport master (
    output s_valid, s_data, cfg_req, cfg_we, cfg_addr, cfg_wdata, fir_result, fir_rdata,
    input  s_ready, m_valid, m_data, cfg_ack, cfg_rdata, cfg_err,
           fir_valid, fir_sample, fir_we, fir_addr, fir_wdata, sample_cnt
  );
endinterface

// File: rtl/fir_ctrl.sv
// Sequencer/arbiter in front of a 4-tap IDLE/SHIFT/CALC FIR core. Issues one
// sample at a time to the core, captures its result, and lets a host read or
// write coefficients only while no calculation is in flight.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset (shared with the core)
//   ctrl_if : fir_ctrl_if.slave (samples, results, host cfg, core port, sample_cnt)
// Optional: define FIR_CTRL_VERIFY_EN to read back every coefficient write
// (VFY_RD/VFY_RW) and flag a mismatch through cfg_err.
module fir_ctrl #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  fir_ctrl_if.slave ctrl_if
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam logic [ADDR_W:0] N_LIM = (ADDR_W+1)'(N);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ISSUE    = 4'd1,
    BUSY1    = 4'd2,
    BUSY2    = 4'd3,
    CAPT     = 4'd4,
    CFG_WR   = 4'd5,
    CFG_RD   = 4'd6,
    CFG_RW   = 4'd7,
    CFG_DONE = 4'd8,
    VFY_RD   = 4'd9,
    VFY_RW   = 4'd10
  } state_e;

  typedef enum logic {
    LAST_SAMPLE = 1'b0,
    LAST_CFG    = 1'b1
  } last_e;

  state_e                state_q, state_d;
  last_e                 last_q, last_d;
  logic                  s_ready_q, s_ready_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cfg_ack_q, cfg_ack_d;
  logic                  cfg_err_q, cfg_err_d;
  logic [DATA_WIDTH-1:0] cfg_rdata_q, cfg_rdata_d;
  logic                  fir_valid_q, fir_valid_d;
  logic [DATA_WIDTH-1:0] fir_sample_q, fir_sample_d;
  logic                  fir_we_q, fir_we_d;
  logic [ADDR_W-1:0]     fir_addr_q, fir_addr_d;
  logic [DATA_WIDTH-1:0] fir_wdata_q, fir_wdata_d;

  logic addr_bad_c;
  logic take_sample_c;

  assign addr_bad_c    = {1'b0, ctrl_if.cfg_addr} >= N_LIM;
  // s_ready is precomputed from the arbitration outcome, so a handshake is the grant
  assign take_sample_c = ctrl_if.s_valid && s_ready_q;

  // Next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    s_ready_d    = 1'b0;
    m_valid_d    = 1'b0;
    m_data_d     = m_data_q;
    cnt_d        = cnt_q;
    cfg_ack_d    = 1'b0;
    cfg_err_d    = 1'b0;
    cfg_rdata_d  = '0;
    fir_valid_d  = 1'b0;
    fir_sample_d = fir_sample_q;
    fir_we_d     = 1'b0;
    fir_addr_d   = fir_addr_q;
    fir_wdata_d  = fir_wdata_q;

    case (state_q)
      IDLE: begin
        if (take_sample_c) begin
          state_d      = ISSUE;
          last_d       = LAST_SAMPLE;
          fir_valid_d  = 1'b1;
          fir_sample_d = ctrl_if.s_data;
        end else if (ctrl_if.cfg_req) begin
          last_d = LAST_CFG;
          if (addr_bad_c) begin
            // out-of-range index never touches the core
            state_d   = CFG_DONE;
            cfg_ack_d = 1'b1;
            cfg_err_d = 1'b1;
          end else if (ctrl_if.cfg_we) begin
            state_d     = CFG_WR;
            fir_we_d    = 1'b1;
            fir_addr_d  = ctrl_if.cfg_addr;
            fir_wdata_d = ctrl_if.cfg_wdata;
          end else begin
            state_d    = CFG_RD;
            fir_addr_d = ctrl_if.cfg_addr;
          end
        end
      end
      ISSUE: state_d = BUSY1;
      BUSY1: state_d = BUSY2;
      BUSY2: state_d = CAPT;
      CAPT: begin
        state_d   = IDLE;
        m_valid_d = 1'b1;
        m_data_d  = ctrl_if.fir_result;
        cnt_d     = cnt_q + CNT_W'(1);
      end
      CFG_WR: begin
`ifdef FIR_CTRL_VERIFY_EN
        state_d = VFY_RD;
`else
        state_d   = CFG_DONE;
        cfg_ack_d = 1'b1;
`endif
      end
      CFG_RD: state_d = CFG_RW;
      CFG_RW: begin
        // core readback is registered: data for CFG_RD's address is valid now
        state_d     = CFG_DONE;
        cfg_ack_d   = 1'b1;
        cfg_rdata_d = ctrl_if.fir_rdata;
      end
`ifdef FIR_CTRL_VERIFY_EN
      VFY_RD: state_d = VFY_RW;
      VFY_RW: begin
        state_d   = CFG_DONE;
        cfg_ack_d = 1'b1;
        cfg_err_d = (ctrl_if.fir_rdata != fir_wdata_q);
      end
`endif
      CFG_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // offer the sample side unless a pending host request is owed its turn
    s_ready_d = (state_d == IDLE) && ((last_d == LAST_CFG) || !ctrl_if.cfg_req);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= LAST_CFG;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      cnt_q        <= '0;
      cfg_ack_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
      fir_valid_q  <= 1'b0;
      fir_sample_q <= '0;
      fir_we_q     <= 1'b0;
      fir_addr_q   <= '0;
      fir_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      cnt_q        <= cnt_d;
      cfg_ack_q    <= cfg_ack_d;
      cfg_err_q    <= cfg_err_d;
      cfg_rdata_q  <= cfg_rdata_d;
      fir_valid_q  <= fir_valid_d;
      fir_sample_q <= fir_sample_d;
      fir_we_q     <= fir_we_d;
      fir_addr_q   <= fir_addr_d;
      fir_wdata_q  <= fir_wdata_d;
    end
  end

  assign ctrl_if.s_ready    = s_ready_q;
  assign ctrl_if.m_valid    = m_valid_q;
  assign ctrl_if.m_data     = m_data_q;
  assign ctrl_if.sample_cnt = cnt_q;
  assign ctrl_if.cfg_ack    = cfg_ack_q;
  assign ctrl_if.cfg_err    = cfg_err_q;
  assign ctrl_if.cfg_rdata  = cfg_rdata_q;
  assign ctrl_if.fir_valid  = fir_valid_q;
  assign ctrl_if.fir_sample = fir_sample_q;
  assign ctrl_if.fir_we     = fir_we_q;
  assign ctrl_if.fir_addr   = fir_addr_q;
  assign ctrl_if.fir_wdata  = fir_wdata_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a behavioural 4-tap FIR core attached.
module tb_fir_ctrl;

  localparam int unsigned DW = 16;
`ifdef FIR_CTRL_VERIFY_EN
  localparam int WR_LAT  = 4;
  localparam int VFY_ERR = 1;
`else
  localparam int WR_LAT  = 2;
  localparam int VFY_ERR = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_ctrl_if #(.DATA_WIDTH(DW)) bus_if ();

  fir_ctrl #(.N(4), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus_if)
  );

  // Core model: coefficients survive reset, taps and readback register do not
  logic [DW-1:0] coeff [16] = '{default: '0};
  logic [DW-1:0] taps  [4];
  logic          corrupt = 1'b0;
  logic [31:0]   acc;

  always @(posedge clk) begin
    if (bus_if.fir_we) coeff[bus_if.fir_addr] <= bus_if.fir_wdata;
    if (rst) begin
      taps[0] <= '0; taps[1] <= '0; taps[2] <= '0; taps[3] <= '0;
      bus_if.fir_rdata <= '0;
    end else begin
      if (bus_if.fir_valid) begin
        taps[0] <= bus_if.fir_sample;
        taps[1] <= taps[0];
        taps[2] <= taps[1];
        taps[3] <= taps[2];
      end
      bus_if.fir_rdata <= corrupt ? ~coeff[bus_if.fir_addr] : coeff[bus_if.fir_addr];
    end
  end

  always_comb begin
    acc = 32'd0;
    for (int k = 0; k < 4; k++) acc = acc + 32'(coeff[k]) * 32'(taps[k]);
    bus_if.fir_result = acc[DW-1:0];
  end

  // Monitors: cycle count, sample window A+1..A+4, fir_we pulses, results
  int cyc = 0;
  int win = 0;
  int we_pulses = 0;
  int overlap = 0;
  int mq_data[$];
  int mq_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) win <= 0;
    else if (bus_if.s_valid && bus_if.s_ready) win <= 4;
    else if (win > 0) win <= win - 1;
  end

  always @(negedge clk) begin
    if (bus_if.fir_we) begin
      we_pulses <= we_pulses + 1;
      if (win > 0) overlap <= overlap + 1;
    end
    if (bus_if.m_valid) begin
      mq_data.push_back(int'(bus_if.m_data));
      mq_cyc.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.s_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Host access issued in an IDLE cycle; lat counts cycles from grant to ack
  task automatic cfg_xfer(input logic we, input logic [3:0] addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output logic err, output int lat);
    int   start;
    logic got;
    bus_if.cfg_req   = 1'b1;
    bus_if.cfg_we    = we;
    bus_if.cfg_addr  = addr;
    bus_if.cfg_wdata = wd;
    start = cyc;
    got   = 1'b0;
    rd    = '0;
    err   = 1'b0;
    lat   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.cfg_ack) begin
        got = 1'b1;
        rd  = bus_if.cfg_rdata;
        err = bus_if.cfg_err;
        lat = cyc - start;
        break;
      end
    end
    bus_if.cfg_req = 1'b0;
    chk("cfg_ack_seen", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] rd;
    logic          err;
    int            lat;
    logic          ok;
    logic          got;
    int            hs [4];
    int            vals [4];
    int            base;
    int            we0;

    vals[0] = 10; vals[1] = 0; vals[2] = 0; vals[3] = 0;
    bus_if.s_valid   = 1'b0;
    bus_if.s_data    = '0;
    bus_if.cfg_req   = 1'b0;
    bus_if.cfg_we    = 1'b0;
    bus_if.cfg_addr  = '0;
    bus_if.cfg_wdata = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_ready",   32'(bus_if.s_ready),    32'd0);
    chk("rst_m_valid",   32'(bus_if.m_valid),    32'd0);
    chk("rst_cfg_ack",   32'(bus_if.cfg_ack),    32'd0);
    chk("rst_cnt",       32'(bus_if.sample_cnt), 32'd0);
    chk("rst_fir_valid", 32'(bus_if.fir_valid),  32'd0);
    chk("rst_fir_we",    32'(bus_if.fir_we),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(bus_if.s_ready), 32'd1);

    // Coefficients 1..4 into addr 0..3
    for (int k = 0; k < 4; k++) begin
      cfg_xfer(1'b1, 4'(k), DW'(k + 1), rd, err, lat);
      chk("wr_err", 32'(err), 32'd0);
      chk("wr_lat", 32'(lat), 32'(WR_LAT));
    end
    chk("wr_we_pulses", 32'(we_pulses), 32'd4);

    // Impulse 10,0,0,0 back-to-back with s_valid held
    mq_data.delete();
    mq_cyc.delete();
    bus_if.s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.s_data = DW'(vals[i]);
      wait_ready(ok);
      chk("b2b_ready_seen", 32'(ok), 32'd1);
      hs[i] = cyc;
      @(negedge clk);
    end
    bus_if.s_valid = 1'b0;
    for (int i = 0; i < 60 && mq_data.size() < 4; i++) @(negedge clk);
    chk("b2b_result_count", 32'(mq_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_m_data", 32'(mq_data[i]), 32'(10 * (i + 1)));
      chk("b2b_latency", 32'(mq_cyc[i] - hs[i]), 32'd5);
      if (i > 0) chk("b2b_spacing", 32'(hs[i] - hs[i-1]), 32'd5);
    end
    chk("b2b_sample_cnt", 32'(bus_if.sample_cnt), 32'd4);

    // Tie in the first IDLE cycle after reset: sample first, then read addr 2
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mq_data.delete();
    mq_cyc.delete();
    bus_if.s_valid  = 1'b1;
    bus_if.s_data   = DW'(5);
    bus_if.cfg_req  = 1'b1;
    bus_if.cfg_we   = 1'b0;
    bus_if.cfg_addr = 4'd2;
    chk("tie_s_ready", 32'(bus_if.s_ready), 32'd1);
    base = cyc;
    @(negedge clk);
    bus_if.s_valid = 1'b0;
    chk("tie_sample_issued", 32'(bus_if.fir_valid), 32'd1);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.cfg_ack) begin
        got = 1'b1;
        lat = cyc - base;
        rd  = bus_if.cfg_rdata;
        err = bus_if.cfg_err;
        break;
      end
    end
    bus_if.cfg_req = 1'b0;
    chk("tie_ack_seen", 32'(got), 32'd1);
    chk("tie_ack_cycle", 32'(lat), 32'd8);
    chk("tie_rdata", 32'(rd), 32'd3);
    chk("tie_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("tie_result_count", 32'(mq_data.size()), 32'd1);
    chk("tie_m_data", 32'(mq_data[0]), 32'd5);
    chk("tie_m_latency", 32'(mq_cyc[0] - base), 32'd5);
    chk("tie_sample_cnt", 32'(bus_if.sample_cnt), 32'd1);
    chk("we_overlap", 32'(overlap), 32'd0);

    // Out-of-range write: rejected, core untouched
    we0 = we_pulses;
    cfg_xfer(1'b1, 4'd7, DW'(16'hBEEF), rd, err, lat);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_rdata", 32'(rd), 32'd0);
    chk("bad_lat", 32'(lat), 32'd1);
    chk("bad_no_we", 32'(we_pulses), 32'(we0));
    for (int k = 0; k < 4; k++) begin
      cfg_xfer(1'b0, 4'(k), '0, rd, err, lat);
      chk("rb_data", 32'(rd), 32'(k + 1));
      chk("rb_err", 32'(err), 32'd0);
      chk("rb_lat", 32'(lat), 32'd3);
    end

    // Write with a corrupted readback path
    corrupt = 1'b1;
    cfg_xfer(1'b1, 4'd3, DW'(4), rd, err, lat);
    corrupt = 1'b0;
    chk("vfy_err", 32'(err), 32'(VFY_ERR));
    chk("vfy_lat", 32'(lat), 32'(WR_LAT));
    cfg_xfer(1'b0, 4'd3, '0, rd, err, lat);
    chk("vfy_rb_data", 32'(rd), 32'd4);

    // Reset at A+3 of a sample
    mq_data.delete();
    mq_cyc.delete();
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = DW'(7);
    wait_ready(ok);
    chk("mid_ready_seen", 32'(ok), 32'd1);
    @(negedge clk);
    bus_if.s_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_m_valid",   32'(bus_if.m_valid),    32'd0);
    chk("mid_m_data",    32'(bus_if.m_data),     32'd0);
    chk("mid_cnt",       32'(bus_if.sample_cnt), 32'd0);
    chk("mid_s_ready",   32'(bus_if.s_ready),    32'd0);
    chk("mid_fir_valid", 32'(bus_if.fir_valid),  32'd0);
    chk("mid_fir_sample",32'(bus_if.fir_sample), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_s_ready_after", 32'(bus_if.s_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("mid_no_result", 32'(mq_data.size()), 32'd0);
    chk("final_we_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_ctrl.md
Name: fir_ctrl

Overview:
- Sequencer and arbiter in front of the 4-tap FIR core (IDLE/SHIFT/CALC core).
- Accepts an upstream sample stream (valid/ready) and issues single-cycle valid pulses to the core only when the core is idle.
- Captures the core result and emits a one-cycle output strobe.
- Shares the core's coefficient port with a host config requester (write/read), so coefficient accesses never overlap a calculation in flight.

Parameters:
- N, 4, number of FIR taps; legal coefficient addresses are 0..N-1.
- DATA_WIDTH, 16, sample, coefficient and result width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  upstream sample valid
- s_data  in  DATA_WIDTH  upstream sample
- s_ready  out  1  controller can accept a sample
- m_valid  out  1  one-cycle result strobe
- m_data  out  DATA_WIDTH  filtered result, valid when m_valid=1
- cfg_req  in  1  host config request; held with cfg_* until cfg_ack
- cfg_we  in  1  1=write coefficient, 0=read
- cfg_addr  in  4  coefficient index
- cfg_wdata  in  DATA_WIDTH  write data
- cfg_ack  out  1  one-cycle completion pulse
- cfg_rdata  out  DATA_WIDTH  read data, valid with cfg_ack on reads
- cfg_err  out  1  valid with cfg_ack; 1 = access rejected or failed
- fir_valid  out  1  to core valid
- fir_sample  out  DATA_WIDTH  to core sample
- fir_result  in  DATA_WIDTH  from core result
- fir_we  out  1  to core we_coeff
- fir_addr  out  4  to core addr_coeff
- fir_wdata  out  DATA_WIDTH  to core data_coeff_i
- fir_rdata  in  DATA_WIDTH  from core data_coeff_o (registered, 1-cycle latency)
- sample_cnt  out  16  count of results emitted; wraps at 0xFFFF -> 0

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; FSM in IDLE; arbitration flag last=CFG, so a sample wins the first tie.
- The core shares rst. Reset mid-operation drops any in-flight sample or config access: no m_valid and no cfg_ack is produced for it.
- FSM states: IDLE, ISSUE, BUSY1, BUSY2, CAPT, CFG_WR, CFG_RD, CFG_RW, CFG_DONE (plus VFY states, see Optional Feature).
- s_ready = 1 only in IDLE when the sample side is granted (see arbitration).
- Arbitration in IDLE: if only one side requests, grant it. If both request, grant the side not served last, then update last.
- Sample path: handshake at cycle A (s_valid & s_ready).
  - A+1 = ISSUE: fir_valid=1 for exactly this cycle; fir_sample=s_data latched at A. fir_sample holds until the next accepted sample.
  - A+2 = BUSY1 (core SHIFT), A+3 = BUSY2 (core CALC).
  - A+4 = CAPT: fir_result sampled.
  - A+5: m_valid=1, m_data=result, sample_cnt+1; FSM back in IDLE.
  - Latency: 5 cycles. Maximum throughput: 1 sample per 5 cycles.
- Config, address check: cfg_addr >= N -> skip core access; CFG_DONE asserts cfg_ack=1, cfg_err=1, cfg_rdata=0.
- Config write: CFG_WR drives fir_we=1 with fir_addr/fir_wdata for exactly one cycle, then CFG_DONE: cfg_ack=1, cfg_err=0.
- Config read: CFG_RD drives fir_addr, CFG_RW waits for the registered core readback, then CFG_DONE: cfg_rdata=fir_rdata, cfg_ack=1, cfg_err=0. Read latency from grant: 3 cycles.
- fir_we is never 1 while a sample is in ISSUE..CAPT.
- A cfg_req arriving mid-sample is deferred to IDLE.
- cfg_ack lasts one cycle. The host must drop or change cfg_req the cycle after ack. If cfg_req is still high, it is treated as a new request.

Optional Feature:
- Macro FIR_CTRL_VERIFY_EN.
- Defined: after CFG_WR, states VFY_RD and VFY_RW read back the same address before CFG_DONE. Mismatch -> cfg_err=1. Write latency grows from 2 to 4 cycles.
- Undefined: no readback; cfg_err reflects only out-of-range addresses.

Test Plan:
- Reset, then write coefficients 1,2,3,4 to addr 0..3 -> each cfg_ack with cfg_err=0, fir_we pulses exactly once per write.
- Samples 10,0,0,0 back-to-back with s_valid held -> s_ready every 5 cycles; m_data = 10,20,30,40; sample_cnt=4; each m_valid 5 cycles after its handshake.
- cfg_req (read addr 2) and s_valid both high in the same IDLE cycle after reset -> sample granted first, read granted next; cfg_rdata=3; fir_we never overlaps ISSUE..CAPT.
- Write to addr 7 with N=4 -> cfg_ack=1, cfg_err=1, fir_we stays 0, coefficients unchanged (readback addr 0..3 = 1..4).
- rst asserted at A+3 of a sample -> no m_valid, outputs 0 next cycle, sample_cnt=0, s_ready=1 the cycle after rst drops.
- With FIR_CTRL_VERIFY_EN, force fir_rdata to a wrong value during VFY_RW -> cfg_err=1; without the macro, the same write -> cfg_err=0, ack 2 cycles after grant.
